// File: rtl/cdc_pkg.sv
// cdc_pkg: shared FIFO read-mode enum and pointer-width helper
package cdc_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: DATA_WIDTH x DEPTH storage, one synchronous write port, one async read port
// Ports:
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data (combinational from raddr_i)
// Contents are not reset.
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with count, almost flags, overflow/underflow pulses and optional FWFT
// Ports:
//   clk_i, rst_i        - clock, synchronous active-high reset
//   we_i, din_i, wrdy_o - write request, data, not-full
//   re_i, dout_o, rrdy_o- read request, data, not-empty
//   count_o             - stored entries
//   almost_full_o       - count_o >= AFULL_THRESH
//   almost_empty_o      - count_o <= AEMPTY_THRESH
//   overflow_o          - pulse after a write attempted while full
//   underflow_o         - pulse after a read attempted while empty
module sync_fifo_param
    import cdc_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 3,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH-1:0]   din_i,
    output logic                    wrdy_o,
    input  logic                    re_i,
    output logic [DATA_WIDTH-1:0]   dout_o,
    output logic                    rrdy_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam bit IS_FWFT = (FWFT == int'(FIFO_FWFT));
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: AEMPTY_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT != int'(FIFO_STD) && FWFT != int'(FIFO_FWFT)) begin : g_bad_mode
        $error("sync_fifo_param: FWFT must be 0 or 1");
    end

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, mem_rdata;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  full, empty, wr_en, rd_en;

    // Full when the wrap bits differ but the addresses coincide.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign wr_en = we_i & ~full & ~rst_i;
    assign rd_en = re_i & ~empty & ~rst_i;

    always_comb begin
        wr_ptr_d    = rst_i ? '0 : wr_ptr_q + PW'(wr_en);
        rd_ptr_d    = rst_i ? '0 : rd_ptr_q + PW'(rd_en);
        count_d     = rst_i ? '0 :
                      (wr_en & ~rd_en) ? count_q + ONE :
                      (rd_en & ~wr_en) ? count_q - ONE : count_q;
        dout_d      = rst_i ? '0 : rd_en ? mem_rdata : dout_q;
        overflow_d  = ~rst_i & we_i & full;
        underflow_d = ~rst_i & re_i & empty;
    end

    always_ff @(posedge clk_i) begin
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
        dout_q      <= dout_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (din_i),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    assign wrdy_o         = ~full;
    assign rrdy_o         = ~empty;
    assign count_o        = count_q;
    assign almost_full_o  = count_q >= AF_T;
    assign almost_empty_o = count_q <= AE_T;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;
    // FWFT shows the head entry directly; standard mode shows the registered pop result.
    assign dout_o         = IS_FWFT ? mem_rdata : dout_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: scoreboard bench for sync_fifo_param in standard and FWFT modes
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst, we, re;
    logic [7:0] din;

    logic       s_wrdy, s_rrdy, s_af, s_ae, s_ovf, s_unf;
    logic [7:0] s_dout;
    logic [2:0] s_count;
    logic       f_wrdy, f_rrdy, f_af, f_ae, f_ovf, f_unf;
    logic [7:0] f_dout;
    logic [2:0] f_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q [$];
    logic [7:0] exp_q [$];
    logic       exp_ovf = 1'b0, exp_unf = 1'b0;
    bit         rd_pend = 1'b0;
    logic [7:0] mon_e;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_std (
        .clk_i(clk), .rst_i(rst), .we_i(we), .din_i(din), .wrdy_o(s_wrdy),
        .re_i(re), .dout_o(s_dout), .rrdy_o(s_rrdy), .count_o(s_count),
        .almost_full_o(s_af), .almost_empty_o(s_ae), .overflow_o(s_ovf), .underflow_o(s_unf)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_fwft (
        .clk_i(clk), .rst_i(rst), .we_i(we), .din_i(din), .wrdy_o(f_wrdy),
        .re_i(re), .dout_o(f_dout), .rrdy_o(f_rrdy), .count_o(f_count),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the reference queue decides acceptance and the
    // expected read data is pushed for the monitor.
    task automatic step(input bit r, input bit w, input bit rd, input logic [7:0] d);
        int  sz;
        bit  wr_ok, rd_ok;
        rst = r; we = w; re = rd; din = d;
        sz    = model_q.size();
        wr_ok = !r && w && sz < 4;
        rd_ok = !r && rd && sz > 0;
        @(posedge clk); #1;
        if (r) begin
            model_q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            exp_ovf = w && sz == 4;
            exp_unf = rd && sz == 0;
            if (rd_ok) exp_q.push_back(model_q.pop_front());
            if (wr_ok) model_q.push_back(d);
        end
        sz = model_q.size();
        chk("count", 32'(s_count), 32'(sz));
        chk("wrdy", 32'(s_wrdy), 32'(sz < 4));
        chk("rrdy", 32'(s_rrdy), 32'(sz > 0));
        chk("afull", 32'(s_af), 32'(sz >= 3));
        chk("aempty", 32'(s_ae), 32'(sz <= 1));
        chk("ovf", 32'(s_ovf), 32'(exp_ovf));
        chk("unf", 32'(s_unf), 32'(exp_unf));
        chk("f_count", 32'(f_count), 32'(sz));
        chk("f_rrdy", 32'(f_rrdy), 32'(sz > 0));
        chk("f_ovf", 32'(f_ovf), 32'(exp_ovf));
    endtask

    // Monitor: pops one expected word for each read the standard DUT accepted,
    // and checks the FWFT head whenever that DUT reports data present.
    always @(negedge clk) begin
        if (rd_pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL std_dout unexpected_read actual=%0h required=none", s_dout);
            end else begin
                mon_e = exp_q.pop_front();
                if (s_dout !== mon_e) begin
                    errors++;
                    $display("FAIL std_dout actual=%0h required=%0h", s_dout, mon_e);
                end
            end
        end
        rd_pend = re && s_rrdy && !rst;
        if (f_rrdy === 1'b1 && model_q.size() > 0) begin
            checks++;
            if (f_dout !== model_q[0]) begin
                errors++;
                $display("FAIL fwft_head actual=%0h required=%0h", f_dout, model_q[0]);
            end
        end
    end

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; din = 8'h00;
        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);
        chk("rst_dout", 32'(s_dout), 32'h0);
        step(0, 0, 0, 8'h00);
        chk("idle_count", 32'(s_count), 32'd0);
        chk("idle_wrdy", 32'(s_wrdy), 32'd1);
        chk("idle_rrdy", 32'(s_rrdy), 32'd0);
        chk("idle_aempty", 32'(s_ae), 32'd1);
        chk("idle_pulses", 32'({s_ovf, s_unf}), 32'd0);

        step(0, 1, 0, 8'h11);
        step(0, 1, 0, 8'h22);
        chk("af_cnt2", 32'(s_af), 32'd0);
        step(0, 1, 0, 8'h33);
        chk("af_cnt3", 32'(s_af), 32'd1);
        step(0, 1, 0, 8'h44);
        chk("full_count", 32'(s_count), 32'd4);
        chk("full_wrdy", 32'(s_wrdy), 32'd0);
        step(0, 1, 0, 8'h55);
        chk("ovf_pulse", 32'(s_ovf), 32'd1);
        chk("ovf_count", 32'(s_count), 32'd4);
        step(0, 0, 0, 8'h00);
        chk("ovf_cleared", 32'(s_ovf), 32'd0);
        step(0, 0, 1, 8'h00);
        chk("rd_11", 32'(s_dout), 32'h11);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        chk("rd_44", 32'(s_dout), 32'h44);

        step(0, 1, 1, 8'hA5);
        chk("unf_pulse", 32'(s_unf), 32'd1);
        chk("unf_count", 32'(s_count), 32'd1);
        step(0, 0, 1, 8'h00);
        chk("rd_a5", 32'(s_dout), 32'hA5);

        step(0, 1, 0, 8'h01);
        step(0, 1, 0, 8'h02);
        step(0, 1, 0, 8'h03);
        step(0, 1, 0, 8'h04);
        step(0, 1, 1, 8'h99);
        chk("full_rw_ovf", 32'(s_ovf), 32'd1);
        chk("full_rw_count", 32'(s_count), 32'd3);
        chk("full_rw_dout", 32'(s_dout), 32'h01);

        for (int i = 0; i < 20; i++) step(0, 1, 1, 8'(8'h60 + i));
        chk("stream_count", 32'(s_count), 32'd3);
        step(0, 0, 1, 8'h00);
        chk("stream_rd0", 32'(s_dout), 32'h71);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h00);
        chk("stream_rd2", 32'(s_dout), 32'h73);

        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h7E);
        chk("fwft_head", 32'(f_dout), 32'h7E);
        step(0, 1, 0, 8'h7F);
        chk("fwft_head_hold", 32'(f_dout), 32'h7E);
        step(1, 1, 0, 8'h80);
        chk("fwft_rst_rrdy", 32'(f_rrdy), 32'd0);
        chk("std_rst_count", 32'(s_count), 32'd0);
        step(0, 0, 0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
